host_iface: RTL and testbench
=============================

HOST_IFACE -- requirements
Module: host_iface

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops in each host strobe synchronizer (minimum 2).
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with ports clk and nrst.
REQ-003 SHALL have these ports, in order:
- clk  in  1  25.175 MHz dot clock, global buffer.
- nrst  in  1  async active-low reset.
- hostBusAddr  in  11  host address, asynchronous.
- hostBusDataIn  in  8  host bus data from the pad.
- hostBusDataOut  out  8  data driven to the host.
- hostBusDataOe  out  1  pad output enable.
- nHostRMEM  in  1  host read strobe, active-low.
- nHostWMEM  in  1  host write strobe, active-low.
- nHostVRAMEn  in  1  VRAM window select, active-low.
- nHostBankRegEn  in  1  bank register select, active-low.
- hostBusDir  out  1  transceiver direction.
- hostAddr  out  13  VRAM host-port address.
- hostWrData  out  8  VRAM write data.
- hostSelect  out  1  VRAM host-port access strobe.
- hostRd  out  1  1 = read, 0 = write.
- hostRdData  in  8  VRAM host-port read data, valid 1 clk after a select.

Function
REQ-004 SHALL pass nHostRMEM, nHostWMEM, nHostVRAMEn and nHostBankRegEn each through a SYNC_STAGES-flop synchronizer before any use.
REQ-005 SHALL register hostBusAddr and hostBusDataIn every clk while the synchronized nHostWMEM or nHostRMEM is low (capture registers).
REQ-006 SHALL keep a 2-bit bank register; hostAddr = {bank, captured addr}.
REQ-007 SHALL implement the FSM states IDLE, WR_COMMIT, RD_REQ, RD_CAPT, RD_HOLD and WAIT_IDLE.
REQ-008 IDLE->WR_COMMIT SHALL occur on a synchronized rising edge of nHostWMEM while sync nHostVRAMEn is low; WR_COMMIT lasts 1 clk with hostSelect=1 and hostRd=0, then goes to IDLE.
REQ-009 On a synchronized nHostWMEM rising edge with sync nHostBankRegEn low, bank SHALL take captured data[1:0] on that clk, with no VRAM access and the FSM staying in IDLE.
REQ-010 IDLE->RD_REQ SHALL occur on a synchronized falling edge of nHostRMEM with sync nHostVRAMEn low; RD_REQ lasts 1 clk with hostSelect=1 and hostRd=1.
REQ-011 In RD_CAPT, hostBusDataOut SHALL take hostRdData; the FSM then goes to RD_HOLD.
REQ-012 A bank register read (sync nHostBankRegEn low, nHostRMEM falling) SHALL load {6'b0, bank} into hostBusDataOut and go directly to RD_HOLD.
REQ-013 In RD_HOLD, hostBusDataOe SHALL be 1 and hostBusDir SHALL be BUS_HOST_READ (0); on sync nHostRMEM high the FSM goes to IDLE with Oe=0.
REQ-014 In every state other than RD_HOLD, hostBusDir SHALL be BUS_HOST_WRITE (1) and hostBusDataOe SHALL be 0.
REQ-015 If both enables are low, nHostBankRegEn SHALL take priority; if both strobes are low, the FSM SHALL go to WAIT_IDLE with no access and leave WAIT_IDLE only when both sync strobes are high.
REQ-016 A strobe edge arriving while the FSM is not in IDLE SHALL be ignored.
REQ-017 hostSelect SHALL be high for exactly 1 clk per access and never for 2 consecutive clks.
REQ-018 Read latency SHALL be SYNC_STAGES+3 clks from the nHostRMEM fall to hostBusDataOe=1.

Reset
REQ-019 While nrst is low: FSM=IDLE, bank=0, all synchronizer flops=1, capture registers=0, hostSelect=0, hostRd=1, hostBusDataOe=0, hostBusDataOut=0, hostBusDir=1, hostAddr=0, hostWrData=0.
REQ-020 Reset asserted mid-access SHALL abort the access, and after release no edge SHALL be detected until a strobe genuinely toggles.

Structure
REQ-021 A shared package SHALL hold BUS_HOST_READ, BUS_HOST_WRITE, the FSM state encoding and BANK_BITS=2.
REQ-022 SHALL use one sub-module, sync_ff (parameterized-depth synchronizer with reset value 1), instantiated per strobe.

Verification
REQ-023 Bank write 0x02 then VRAM write addr 0x123, data 0x5A -> hostAddr=0x1123, hostWrData=0x5A, hostRd=0, one hostSelect pulse.
REQ-024 VRAM read at 0x7FF with hostRdData=0xC3 at bank 3 -> hostAddr=0x1FFF, hostBusDataOut=0xC3 and Oe=1 after SYNC_STAGES+3 clks, hostBusDir=0 until nHostRMEM rises.
REQ-025 Bank register read after bank write 0x01 -> hostBusDataOut=0x01, and hostSelect never asserted.
REQ-026 nHostRMEM and nHostWMEM low together -> no hostSelect, Oe=0, FSM returns to IDLE after both go high.
REQ-027 nrst pulsed during RD_HOLD -> Oe=0 immediately, bank=0, no spurious access after release.
REQ-028 nHostWMEM pulse with both enables high -> no VRAM access and bank unchanged.

Source files
------------

// File: rtl/host_iface_pkg.sv
// Shared definitions for the host bus interface: bus direction codes, FSM state
// encoding and address/bank widths.
package host_iface_pkg;

    localparam logic BUS_HOST_READ  = 1'b0;
    localparam logic BUS_HOST_WRITE = 1'b1;

    localparam int BANK_BITS      = 2;
    localparam int ADDR_BITS      = 11;
    localparam int DATA_BITS      = 8;
    localparam int HOST_ADDR_BITS = BANK_BITS + ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_COMMIT = 3'd1,
        RD_REQ    = 3'd2,
        RD_CAPT   = 3'd3,
        RD_HOLD   = 3'd4,
        WAIT_IDLE = 3'd5
    } hostState_t;

    // Bank register as seen on the host data bus when read back.
    function automatic logic [DATA_BITS-1:0] bankReadback(input logic [BANK_BITS-1:0] bank);
        return {{(DATA_BITS - BANK_BITS){1'b0}}, bank};
    endfunction

endpackage

// File: rtl/host_iface_sync_ff.sv
// Multi-flop synchronizer for one asynchronous host strobe; every flop resets to 1
// so an idle (high) strobe is what the logic sees straight out of reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/host_iface.sv
// Bridges the asynchronous host memory bus onto the synchronous VRAM host port,
// with a 2-bit bank register extending the 11-bit host window to 13 bits.
module host_iface
    import host_iface_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [ADDR_BITS-1:0]      hostBusAddr,
    input  logic [DATA_BITS-1:0]      hostBusDataIn,
    output logic [DATA_BITS-1:0]      hostBusDataOut,
    output logic                      hostBusDataOe,
    input  logic                      nHostRMEM,
    input  logic                      nHostWMEM,
    input  logic                      nHostVRAMEn,
    input  logic                      nHostBankRegEn,
    output logic                      hostBusDir,
    output logic [HOST_ADDR_BITS-1:0] hostAddr,
    output logic [DATA_BITS-1:0]      hostWrData,
    output logic                      hostSelect,
    output logic                      hostRd,
    input  logic [DATA_BITS-1:0]      hostRdData
);

    logic syncRMem;
    logic syncWMem;
    logic syncVramEn;
    logic syncBankEn;

    logic prevRMem;
    logic prevWMem;
    logic [SYNC_STAGES:0] armPipe;
    logic armed;
    logic rdFall;
    logic wrRise;

    logic [ADDR_BITS-1:0] capAddr;
    logic [DATA_BITS-1:0] capData;
    logic [BANK_BITS-1:0] bank;
    hostState_t state;

    sync_ff #(.STAGES(SYNC_STAGES)) uSyncRMem (
        .clk (clk),
        .nrst(nrst),
        .d   (nHostRMEM),
        .q   (syncRMem)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) uSyncWMem (
        .clk (clk),
        .nrst(nrst),
        .d   (nHostWMEM),
        .q   (syncWMem)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) uSyncVramEn (
        .clk (clk),
        .nrst(nrst),
        .d   (nHostVRAMEn),
        .q   (syncVramEn)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) uSyncBankEn (
        .clk (clk),
        .nrst(nrst),
        .d   (nHostBankRegEn),
        .q   (syncBankEn)
    );

    // Edge detection stays disarmed until the synchronizers and the previous-value
    // flops hold real pad samples, so a strobe already low at reset release is not
    // mistaken for a fresh falling edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prevRMem <= 1'b1;
            prevWMem <= 1'b1;
            armPipe  <= '0;
        end else begin
            prevRMem <= syncRMem;
            prevWMem <= syncWMem;
            armPipe  <= {armPipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign armed  = armPipe[SYNC_STAGES];
    assign rdFall = armed && prevRMem && !syncRMem;
    assign wrRise = armed && !prevWMem && syncWMem;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            capAddr <= '0;
            capData <= '0;
        end else if (!syncWMem || !syncRMem) begin
            capAddr <= hostBusAddr;
            capData <= hostBusDataIn;
        end
    end

    assign hostAddr   = {bank, capAddr};
    assign hostWrData = capData;

    // Bank register enable outranks the VRAM enable; overlapping strobes park in
    // WAIT_IDLE until the host releases both.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= IDLE;
            bank           <= '0;
            hostSelect     <= 1'b0;
            hostRd         <= 1'b1;
            hostBusDataOe  <= 1'b0;
            hostBusDataOut <= '0;
            hostBusDir     <= BUS_HOST_WRITE;
        end else begin
            hostSelect <= 1'b0;
            case (state)
                IDLE: begin
                    if (!syncRMem && !syncWMem) begin
                        state <= WAIT_IDLE;
                    end else if (wrRise) begin
                        if (!syncBankEn) begin
                            bank <= capData[BANK_BITS-1:0];
                        end else if (!syncVramEn) begin
                            state      <= WR_COMMIT;
                            hostSelect <= 1'b1;
                            hostRd     <= 1'b0;
                        end
                    end else if (rdFall) begin
                        if (!syncBankEn) begin
                            hostBusDataOut <= bankReadback(bank);
                            hostBusDataOe  <= 1'b1;
                            hostBusDir     <= BUS_HOST_READ;
                            state          <= RD_HOLD;
                        end else if (!syncVramEn) begin
                            state      <= RD_REQ;
                            hostSelect <= 1'b1;
                            hostRd     <= 1'b1;
                        end
                    end
                end

                WR_COMMIT: begin
                    hostRd <= 1'b1;
                    state  <= IDLE;
                end

                RD_REQ: begin
                    state <= RD_CAPT;
                end

                RD_CAPT: begin
                    hostBusDataOut <= hostRdData;
                    hostBusDataOe  <= 1'b1;
                    hostBusDir     <= BUS_HOST_READ;
                    state          <= RD_HOLD;
                end

                RD_HOLD: begin
                    if (syncRMem) begin
                        hostBusDataOe <= 1'b0;
                        hostBusDir    <= BUS_HOST_WRITE;
                        state         <= IDLE;
                    end
                end

                WAIT_IDLE: begin
                    if (syncRMem && syncWMem) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    hostBusDataOe <= 1'b0;
                    hostBusDir    <= BUS_HOST_WRITE;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_iface.sv
// Directed bench for host_iface: a scoreboard queue of expected VRAM accesses is
// filled as host cycles are driven and drained whenever hostSelect pulses.
module tb_host_iface;

    localparam int SYNC = 2;

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  data;
        logic        rd;
    } access_t;

    logic        clk;
    logic        nrst;
    logic [10:0] hostBusAddr;
    logic [7:0]  hostBusDataIn;
    logic [7:0]  hostBusDataOut;
    logic        hostBusDataOe;
    logic        nHostRMEM;
    logic        nHostWMEM;
    logic        nHostVRAMEn;
    logic        nHostBankRegEn;
    logic        hostBusDir;
    logic [12:0] hostAddr;
    logic [7:0]  hostWrData;
    logic        hostSelect;
    logic        hostRd;
    logic [7:0]  hostRdData;

    access_t expQ[$];
    int      checkCount = 0;
    int      passCount  = 0;
    int      selectCount = 0;
    int      pushCount  = 0;
    logic    prevSel = 1'b0;
    logic [7:0] rdValue = 8'h00;
    logic [1:0] modelBank = 2'd0;

    host_iface #(.SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .hostBusAddr   (hostBusAddr),
        .hostBusDataIn (hostBusDataIn),
        .hostBusDataOut(hostBusDataOut),
        .hostBusDataOe (hostBusDataOe),
        .nHostRMEM     (nHostRMEM),
        .nHostWMEM     (nHostWMEM),
        .nHostVRAMEn   (nHostVRAMEn),
        .nHostBankRegEn(nHostBankRegEn),
        .hostBusDir    (hostBusDir),
        .hostAddr      (hostAddr),
        .hostWrData    (hostWrData),
        .hostSelect    (hostSelect),
        .hostRd        (hostRd),
        .hostRdData    (hostRdData)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // VRAM host port model: data for a read select appears one clock later.
    always @(posedge clk) begin
        if (hostSelect && hostRd) hostRdData <= rdValue;
        else                      hostRdData <= 8'hEE;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Every hostSelect pulse must match the oldest expected access.
    always @(negedge clk) begin
        if (nrst && hostSelect) begin
            selectCount++;
            checkOutput("select back-to-back", prevSel, 1'b0);
            checkOutput("select expected", expQ.size() > 0, 1'b1);
            if (expQ.size() > 0) begin
                access_t e;
                e = expQ.pop_front();
                checkOutput("access addr", hostAddr, e.addr);
                checkOutput("access rd", hostRd, e.rd);
                if (!e.rd) checkOutput("access wrData", hostWrData, e.data);
            end
        end
        prevSel = hostSelect;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #5;
    endtask

    task automatic applyStimulus(input logic rm, input logic wm, input logic vramEn, input logic bankEn,
                                 input logic [10:0] addr, input logic [7:0] data);
        nHostRMEM      = rm;
        nHostWMEM      = wm;
        nHostVRAMEn    = vramEn;
        nHostBankRegEn = bankEn;
        hostBusAddr    = addr;
        hostBusDataIn  = data;
    endtask

    task automatic pushAccess(input logic [12:0] addr, input logic [7:0] data, input logic rd);
        access_t e;
        e.addr = addr;
        e.data = data;
        e.rd   = rd;
        expQ.push_back(e);
        pushCount++;
    endtask

    task automatic hostWrite(input logic vramEn, input logic bankEn, input logic [10:0] addr, input logic [7:0] data);
        applyStimulus(1'b1, 1'b1, vramEn, bankEn, addr, data);
        tick(2);
        applyStimulus(1'b1, 1'b0, vramEn, bankEn, addr, data);
        tick(4);
        applyStimulus(1'b1, 1'b1, vramEn, bankEn, addr, data);
        tick(4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, addr, data);
        tick(2);
    endtask

    task automatic bankWrite(input logic [7:0] data);
        hostWrite(1'b1, 1'b0, 11'h000, data);
        modelBank = data[1:0];
    endtask

    task automatic hostReadStart(input logic vramEn, input logic bankEn, input logic [10:0] addr, output int cycles);
        applyStimulus(1'b1, 1'b1, vramEn, bankEn, addr, 8'h00);
        tick(2);
        applyStimulus(1'b0, 1'b1, vramEn, bankEn, addr, 8'h00);
        cycles = 0;
        while (!hostBusDataOe && cycles < 20) begin
            tick(1);
            cycles++;
        end
    endtask

    task automatic hostReadEnd();
        applyStimulus(1'b1, 1'b1, nHostVRAMEn, nHostBankRegEn, hostBusAddr, 8'h00);
        tick(SYNC + 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, hostBusAddr, 8'h00);
        tick(2);
    endtask

    initial begin
        int lat;
        int selBefore;

        $display("[TB] host_iface bench start");
        nrst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 11'h000, 8'h00);
        tick(3);
        checkOutput("reset hostSelect", hostSelect, 1'b0);
        checkOutput("reset hostRd", hostRd, 1'b1);
        checkOutput("reset Oe", hostBusDataOe, 1'b0);
        checkOutput("reset dataOut", hostBusDataOut, 8'h00);
        checkOutput("reset dir", hostBusDir, 1'b1);
        checkOutput("reset hostAddr", hostAddr, 13'h0000);
        checkOutput("reset wrData", hostWrData, 8'h00);
        nrst = 1'b1;
        tick(5);

        // Bank 2 then a VRAM write at 0x123.
        bankWrite(8'h02);
        checkOutput("bank write 2 addr", hostAddr, 13'h1000);
        pushAccess({modelBank, 11'h123}, 8'h5A, 1'b0);
        hostWrite(1'b0, 1'b1, 11'h123, 8'h5A);
        checkOutput("write drained", expQ.size(), 0);
        checkOutput("write select count", selectCount, 1);
        checkOutput("hostRd idle after write", hostRd, 1'b1);

        // VRAM read at 0x7FF in bank 3.
        bankWrite(8'h03);
        rdValue = 8'hC3;
        pushAccess({modelBank, 11'h7FF}, 8'h00, 1'b1);
        hostReadStart(1'b0, 1'b1, 11'h7FF, lat);
        checkOutput("read latency", lat, SYNC + 3);
        checkOutput("read data", hostBusDataOut, 8'hC3);
        checkOutput("read Oe", hostBusDataOe, 1'b1);
        checkOutput("read dir", hostBusDir, 1'b0);
        checkOutput("read hostAddr", hostAddr, 13'h1FFF);
        tick(3);
        checkOutput("read hold Oe", hostBusDataOe, 1'b1);
        checkOutput("read hold dir", hostBusDir, 1'b0);
        hostReadEnd();
        checkOutput("read end Oe", hostBusDataOe, 1'b0);
        checkOutput("read end dir", hostBusDir, 1'b1);

        // Bank register readback without any VRAM access.
        bankWrite(8'h01);
        selBefore = selectCount;
        hostReadStart(1'b1, 1'b0, 11'h000, lat);
        checkOutput("bank read latency", lat, SYNC + 1);
        checkOutput("bank read data", hostBusDataOut, 8'h01);
        checkOutput("bank read dir", hostBusDir, 1'b0);
        hostReadEnd();
        checkOutput("bank read no select", selectCount, selBefore);

        // Both strobes together: no access, then a normal write proves IDLE again.
        selBefore = selectCount;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 11'h055, 8'hA7);
        tick(6);
        checkOutput("both low Oe", hostBusDataOe, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 11'h055, 8'hA7);
        tick(6);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 11'h055, 8'hA7);
        tick(2);
        checkOutput("both low no select", selectCount, selBefore);
        pushAccess({modelBank, 11'h055}, 8'hA7, 1'b0);
        hostWrite(1'b0, 1'b1, 11'h055, 8'hA7);
        checkOutput("post overlap write drained", expQ.size(), 0);

        // Reset while holding a read.
        rdValue = 8'h3C;
        pushAccess({modelBank, 11'h010}, 8'h00, 1'b1);
        hostReadStart(1'b0, 1'b1, 11'h010, lat);
        checkOutput("pre-reset read data", hostBusDataOut, 8'h3C);
        nrst = 1'b0;
        modelBank = 2'd0;
        #1;
        checkOutput("reset mid-read Oe", hostBusDataOe, 1'b0);
        checkOutput("reset mid-read dir", hostBusDir, 1'b1);
        checkOutput("reset mid-read hostAddr", hostAddr, 13'h0000);
        tick(2);
        selBefore = selectCount;
        nrst = 1'b1;
        tick(8);
        checkOutput("post-reset Oe", hostBusDataOe, 1'b0);
        checkOutput("post-reset no select", selectCount, selBefore);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 11'h010, 8'h00);
        tick(4);
        hostReadStart(1'b1, 1'b0, 11'h000, lat);
        checkOutput("post-reset bank", hostBusDataOut, 8'h00);
        hostReadEnd();

        // Write strobe with no enable leaves the bank alone.
        selBefore = selectCount;
        hostWrite(1'b1, 1'b1, 11'h2AA, 8'h03);
        checkOutput("no-enable write no select", selectCount, selBefore);
        hostReadStart(1'b1, 1'b0, 11'h000, lat);
        checkOutput("no-enable bank unchanged", hostBusDataOut, {6'b0, modelBank});
        hostReadEnd();

        checkOutput("scoreboard empty", expQ.size(), 0);
        checkOutput("total selects", selectCount, pushCount);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
